// File: rtl/pipelined_addsub_if.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_if
//
// Purpose:
//   Groups the operand-side and result-side valid/ready channels of the
//   pipelined adder/subtractor into one bundle.
//
// Signals:
//   in_valid   operands and mode are valid this cycle        (source -> block)
//   in_ready   block accepts the input this cycle            (block -> source)
//   in_a       operand A, WIDTH bits                         (source -> block)
//   in_b       operand B, WIDTH bits                         (source -> block)
//   in_sub     0 = A+B, 1 = A-B                              (source -> block)
//   out_valid  result is valid this cycle                    (block -> sink)
//   out_ready  downstream accepts the result                 (sink  -> block)
//   out_sum    result modulo 2^WIDTH                         (block -> sink)
//   out_cout   unsigned carry-out (subtract: 1 = no borrow)  (block -> sink)
//   out_ovf    signed two's-complement overflow              (block -> sink)
//   out_zero   out_sum == 0                                  (block -> sink)
//
// Modports:
//   master  the environment side: drives operands and out_ready.
//   slave   the arithmetic block side: drives in_ready and the result.
// -----------------------------------------------------------------------------
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout,
        input  out_ovf,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout,
        output out_ovf,
        output out_zero
    );
endinterface : pipelined_addsub_if

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//
// Purpose:
//   WIDTH-bit adder/subtractor split into STAGES chunks of CW = WIDTH/STAGES
//   bits. Each pipeline stage adds one chunk and registers the carry into the
//   next stage. The whole pipe advances together and freezes together when the
//   result at the output is not taken (global stall), so results leave in
//   acceptance order with no drops or duplicates.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous, active-high reset; clears every stage and the outputs
//   bus   pipelined_addsub_if.slave:
//           in_valid/in_ready/in_a/in_b/in_sub    operand channel
//           out_valid/out_ready                   result channel handshake
//           out_sum/out_cout/out_ovf/out_zero     result and flags
//
// Timing:
//   An operation accepted at edge N is visible with out_valid high after
//   edge N+STAGES-1. Stage k register holds the operation after chunk k has
//   been computed; the last stage register is the output register.
// -----------------------------------------------------------------------------
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_addsub_if.slave bus
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
    end

    // -------------------------------------------------------------------------
    // Stage state. Entry k is the register at the output of stage k.
    //   a_q/b_q  operands travelling with the operation (b already inverted
    //            for subtract); chunks above k are still to be consumed
    //   s_q      partial sum; chunks 0..k are final
    //   c_q      carry out of chunk k, i.e. carry into chunk k+1
    // -------------------------------------------------------------------------
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q;

    logic             vld_d [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             ovf_d;

    logic             stall;

    // The pipe moves as one unit: it only freezes when the output holds a
    // result that the sink refuses. A bubble at the output never blocks.
    assign stall        = vld_q[LAST] && !bus.out_ready;
    assign bus.in_ready = !stall;

    // -------------------------------------------------------------------------
    // Per-stage chunk adder
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] s_prev;
        logic             carry_in;
        logic [CW:0]      chunk;
        logic [WIDTH-1:0] s_ins;

        if (k == 0) begin : g_head
            // Subtract is A + ~B + 1: invert B once here and feed the +1 in
            // as the carry into chunk 0. The inverted B then travels with the
            // operation so later stages do not need to know the mode.
            assign vld_d[k]  = bus.in_valid;
            assign a_d[k]    = bus.in_a;
            assign b_d[k]    = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign s_prev    = '0;
            assign carry_in  = bus.in_sub;
        end else begin : g_body
            assign vld_d[k]  = vld_q[k-1];
            assign a_d[k]    = a_q[k-1];
            assign b_d[k]    = b_q[k-1];
            assign s_prev    = s_q[k-1];
            assign carry_in  = c_q[k-1];
        end

        assign chunk = {1'b0, a_d[k][k*CW +: CW]}
                     + {1'b0, b_d[k][k*CW +: CW]}
                     + {{CW{1'b0}}, carry_in};

        // NOTE: every variable written in always_comb gets a full default
        // before any partial update; otherwise the untouched bits would have
        // to remember their old value and a latch would be inferred.
        always_comb begin
            s_ins                = s_prev;
            s_ins[k*CW +: CW]    = chunk[CW-1:0];
        end

        assign s_d[k] = s_ins;
        assign c_d[k] = chunk[CW];
    end : g_stage

    // Signed overflow: both addends share a sign and the result sign differs.
    // This equals carry-into-MSB XOR carry-out-of-MSB. b_d is the possibly
    // inverted B, so the same rule covers subtract.
    assign ovf_d = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1])
                && (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so that
    // every stage samples its predecessor's value from before the edge; with
    // blocking assignments an operation would shoot through several stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are cleared along with the valid bits
            // because the result and flags must read 0 straight after reset,
            // not just be marked invalid.
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all taken from the last stage register
    // -------------------------------------------------------------------------
    assign bus.out_valid = vld_q[LAST];
    assign bus.out_sum   = s_q[LAST];
    assign bus.out_cout  = c_q[LAST];
    assign bus.out_ovf   = ovf_q;
    // Qualified with valid so the flag reads 0 after reset even though the
    // cleared sum register is itself zero.
    assign bus.out_zero  = vld_q[LAST] && (s_q[LAST] == '0);

endmodule : pipelined_addsub

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Directed bench for pipelined_addsub: a 32-bit/4-stage instance for the main
// scenarios and an 8-bit/1-stage instance for the single-register case.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(32)) bus32 ();
    pipelined_addsub_if #(.WIDTH(8))  bus8  ();

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Packed view of the 32-bit result channel: {valid, cout, ovf, zero, sum}.
    function automatic logic [35:0] obs32();
        return {bus32.out_valid, bus32.out_cout, bus32.out_ovf, bus32.out_zero, bus32.out_sum};
    endfunction

    function automatic logic [11:0] obs8();
        return {bus8.out_valid, bus8.out_cout, bus8.out_ovf, bus8.out_zero, bus8.out_sum};
    endfunction

    // Reference model, written as plain full-width arithmetic and the
    // textbook sign rules. Returns {cout, ovf, zero, sum}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] full;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            s    = full[31:0];
            cout = (a >= b);
            ovf  = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            s    = full[31:0];
            cout = full[32];
            ovf  = (a[31] == b[31]) && (s[31] != a[31]);
        end
        return {cout, ovf, (s == 32'h0), s};
    endfunction

    // Present one operation for a single edge (pipe assumed free).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus32.in_valid = 1'b1;
        bus32.in_a     = a;
        bus32.in_b     = b;
        bus32.in_sub   = sub;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    // Called just after the acceptance edge N: out_valid must still be low
    // after edge N+2 and the result must be present after edge N+3.
    task automatic wait_result(input string tag, input logic [35:0] exp);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_early"}, bus32.out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check(tag, obs32(), exp);
    endtask

    // Stream test state
    logic [35:0] exp_q [$];
    logic        stream_done;
    logic [5:0]  ready_pat = 6'b101001;   // bit i = out_ready in cycle i: 1,0,0,1,0,1

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_a      = '0;
        bus32.in_b      = '0;
        bus32.in_sub    = 1'b0;
        bus32.out_ready = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.in_a       = '0;
        bus8.in_b       = '0;
        bus8.in_sub     = 1'b0;
        bus8.out_ready  = 1'b1;
        stream_done     = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out32", obs32(), 36'h0);
        check("reset_in_ready", bus32.in_ready, 1'b1);
        check("reset_out8", obs8(), 12'h0);
        @(posedge clk);
        #1;

        // ---------------- 1: signed overflow on add ----------------
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_result("t1_ovf_add", {1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000});

        // ---------------- 2: carry ripples through all chunks ----------------
        @(posedge clk);
        #1;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_result("t2_ripple", {1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000});

        // ---------------- 3: back-to-back subtracts ----------------
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b1;
        bus32.in_a     = 32'd5;
        bus32.in_b     = 32'd7;
        bus32.in_sub   = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_a     = 32'h8000_0000;
        bus32.in_b     = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t3_sub_borrow", obs32(), {1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        @(posedge clk);
        @(negedge clk);
        check("t3_sub_ovf", obs32(), {1'b1, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});
        @(posedge clk);
        #1;

        // ---------------- 4: stream under back-pressure ----------------
        fork
            begin : driver
                for (int i = 0; i < 16; i++) begin
                    logic [31:0] a;
                    logic [31:0] b;
                    logic        sub;
                    bit          accepted;
                    int          w;
                    a        = $urandom;
                    b        = $urandom;
                    sub      = 1'($urandom_range(0, 1));
                    bus32.in_valid = 1'b1;
                    bus32.in_a     = a;
                    bus32.in_b     = b;
                    bus32.in_sub   = sub;
                    accepted = 1'b0;
                    w        = 0;
                    while (!accepted && w < 100) begin
                        @(negedge clk);
                        if (bus32.in_ready) begin
                            exp_q.push_back({1'b1, model(a, b, sub)});
                            accepted = 1'b1;
                        end
                        @(posedge clk);
                        #1;
                        w++;
                    end
                    if (!accepted) check("t4_accept_timeout", 1'b0, 1'b1);
                end
                bus32.in_valid = 1'b0;
            end
            begin : ready_gen
                int k;
                k = 0;
                while (!stream_done && k < 1000) begin
                    bus32.out_ready = ready_pat[k % 6];
                    k++;
                    @(posedge clk);
                    #1;
                end
            end
            begin : monitor
                int          got;
                int          cyc;
                logic        prev_stall;
                logic [35:0] prev_obs;
                got        = 0;
                cyc        = 0;
                prev_stall = 1'b0;
                prev_obs   = '0;
                while (got < 16 && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                    check("t4_in_ready", bus32.in_ready, !(bus32.out_valid && !bus32.out_ready));
                    if (prev_stall) check("t4_hold", obs32(), prev_obs);
                    if (bus32.out_valid && bus32.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("t4_unexpected", 1'b1, 1'b0);
                        end else begin
                            check($sformatf("t4_res%0d", got), obs32(), exp_q.pop_front());
                        end
                        got++;
                    end
                    prev_stall = bus32.out_valid && !bus32.out_ready;
                    prev_obs   = obs32();
                end
                check("t4_count", got, 16);
                stream_done = 1'b1;
            end
        join
        bus32.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t4_leftover", exp_q.size(), 0);

        // ---------------- 5: reset discards in-flight work ----------------
        bus32.in_valid = 1'b1;
        bus32.in_sub   = 1'b0;
        bus32.in_a     = 32'h1111_1111;
        bus32.in_b     = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus32.in_a     = 32'h2222_2222;
        @(posedge clk);
        #1;
        bus32.in_a     = 32'h3333_3333;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_reset_out", obs32(), 36'h0);
        begin
            int ghosts;
            ghosts = 0;
            for (int i = 0; i < 8; i++) begin
                if (bus32.out_valid) ghosts++;
                @(negedge clk);
            end
            check("t5_ghosts", ghosts, 0);
        end
        @(posedge clk);
        #1;
        issue(32'd1, 32'd2, 1'b0);
        wait_result("t5_after_reset", {1'b1, 1'b0, 1'b0, 1'b0, 32'd3});

        // ---------------- 6: single-stage 8-bit instance ----------------
        @(negedge clk);
        check("t6_idle", bus8.out_valid, 1'b0);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b1;
        bus8.in_a     = 8'h80;
        bus8.in_b     = 8'h01;
        bus8.in_sub   = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_a     = 8'hFF;
        bus8.in_b     = 8'h01;
        bus8.in_sub   = 1'b0;
        @(negedge clk);
        check("t6_sub_ovf", obs8(), {1'b1, 1'b1, 1'b1, 1'b0, 8'h7F});
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check("t6_add_wrap", obs8(), {1'b1, 1'b1, 1'b0, 1'b1, 8'h00});
        @(posedge clk);
        @(negedge clk);
        check("t6_drained", bus8.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipelined_addsub

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the datapath's 32-bit combinational adder; used for the ALU add/sub path and for branch/PC target arithmetic where timing must be closed at higher clock rates.
- Splits a WIDTH-bit add or subtract into STAGES chunks, one chunk per pipeline stage, with carry registered between stages.
- Adds subtract mode, carry-out, signed-overflow and zero flags, and a valid/ready handshake with back-pressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; must be ≥1. Each stage adds CW = WIDTH/STAGES bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B; 1 = A−B.
- out_valid  output  1  result is valid this cycle.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_cout  output  1  unsigned carry-out. For subtract, 1 = no borrow (A ≥ B unsigned).
- out_ovf  output  1  signed two's-complement overflow.
- out_zero  output  1  out_sum == 0.

Behaviour:
- Reset
  - When rst is high at a clock edge, all stage valid bits clear.
  - out_valid, out_sum, out_cout, out_ovf and out_zero all read 0.
  - rst takes priority over every other input. Any in-flight operations are discarded and are never emitted.
- Handshake and stall
  - Global stall condition: stall = out_valid && !out_ready.
  - in_ready = !stall. This output is combinational.
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - When stall is low, every stage advances by one. Stage 1 loads the new operation, or a bubble if in_valid is low.
  - When stall is high, all stage registers hold their contents, including the output stage.
  - Bubbles are not compressed.
- Latency and throughput
  - An operation accepted at edge N is presented with out_valid high after edge N+STAGES−1 completes, i.e. in the STAGES-th cycle after acceptance. Count the acceptance cycle as cycle 0; out_valid rises in cycle STAGES.
  - Throughput is one operation per cycle when out_ready is held high.
  - Results leave in acceptance order. No operation is dropped or duplicated under any pattern of out_ready.
- Arithmetic
  - Define b' = in_sub ? ~in_b : in_b and cin0 = in_sub.
  - Stage k (k = 0..STAGES−1) computes bits [k·CW +: CW] as A_chunk + b'_chunk + c_k.
  - c_0 = cin0. c_{k+1} is the registered carry-out of stage k.
  - Operand chunks not yet consumed travel down the pipeline with the operation.
  - Result chunks already computed are carried forward with the operation.
  - out_cout = carry out of bit WIDTH−1.
  - out_ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - out_zero is computed from the final registered sum.
  - With STAGES = 1 the block is a single registered add/sub with the same flags and handshake.
- Boundary conditions
  - A carry must ripple across every chunk boundary correctly, e.g. 0xFFFFFFFF + 1.
  - in_sub is captured per operation, so mixed add/sub back-to-back is legal.
  - in_valid while in_ready is low: the inputs are ignored. The source must hold them until they are accepted.
  - out_ready may toggle every cycle. out_sum and the flags must stay stable while out_valid && !out_ready.

Test Plan:
WIDTH=32, STAGES=4, out_ready=1 unless stated.
1. Add 0x7FFFFFFF + 0x00000001 -> 4 cycles after acceptance: out_sum=0x80000000, out_cout=0, out_ovf=1, out_zero=0.
2. Add 0xFFFFFFFF + 0x00000001 -> out_sum=0x00000000, out_cout=1, out_ovf=0, out_zero=1. Checks carry rippling through all 4 stages.
3. Subtract 5 − 7 -> out_sum=0xFFFFFFFE, out_cout=0, out_ovf=0. Then subtract 0x80000000 − 1 -> out_sum=0x7FFFFFFF, out_cout=1, out_ovf=1. Both issued back-to-back, and the results must appear on consecutive cycles.
4. Stream 16 random add/sub operations while out_ready follows the pattern 1,0,0,1,0,1,… -> all 16 results match the reference model in order. in_ready is low exactly when out_valid && !out_ready. Outputs stay stable during each stall.
5. Accept 3 operations, then assert rst for 1 cycle on the next edge -> out_valid=0 and all outputs 0 on the following cycle. None of the 3 results ever appears. A new operation 1 + 2 accepted afterwards returns 3 after 4 cycles.
6. Instantiate with STAGES=1, WIDTH=8 and compute 0x80 − 0x01 -> on the next cycle: out_sum=0x7F, out_ovf=1, out_cout=1.
